// File: rtl/rv32i_types.sv
// Shared dmem types: responder FSM states, byte-lane mask constants, request payload.
package rv32i_types;

  typedef enum logic [1:0] {
    DRSP_IDLE,
    DRSP_WAIT,
    DRSP_RESP
  } dmem_rsp_state_t;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  localparam int unsigned DMEM_CNT_W = 5;

  // Latched request; only the word address is kept, byte offset is implied by the masks.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  m);
    return (new_w & lane_bits(m)) | (old_w & ~lane_bits(m));
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1); built only with DMEM_RAND_LAT_EN.
`ifdef DMEM_RAND_LAT_EN
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'hACE1;
    end else if (en) begin
      out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
    end
  end

endmodule
`endif

// File: rtl/dmem_responder.sv
// Responder side of the dmem request/response interface backed by a byte-lane register array.
// Optional random extra latency (0..3 cycles) when DMEM_RAND_LAT_EN is defined.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS),
  parameter logic [31:0] BASE_ADDR = 32'h1ECEB000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      dmem_addr,
  input  logic [3:0]       dmem_rmask,
  input  logic [3:0]       dmem_wmask,
  input  logic [31:0]      dmem_wdata,
  output logic [31:0]      dmem_rdata,
  output logic             dmem_resp,
  input  logic             init_we,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [31:0]      init_data,
  output logic             dmem_err
);

  localparam int unsigned CNT_W  = DMEM_CNT_W;
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

  dmem_rsp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_total_c;
  dmem_req_t        req_q, live_c, acc_c;

  logic             req_c;
  logic             accept_c, drop_c, access_c;
  logic [29:0]      word_off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      rd_word_c, wr_base_c;
  logic             mem_wr_c, err_set_c;
  logic             addr_lsb_unused;

  logic [31:0] mem [MEM_WORDS];

  assign addr_lsb_unused = ^dmem_addr[1:0];

`ifdef DMEM_RAND_LAT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .out   (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:2];
  assign lat_total_c = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_total_c = CNT_W'(LATENCY);
`endif

  assign req_c = |(dmem_rmask | dmem_wmask);

  always_comb begin
    live_c       = '0;
    live_c.waddr = dmem_addr[31:2];
    live_c.rmask = dmem_rmask;
    live_c.wmask = dmem_wmask;
    live_c.wdata = dmem_wdata;
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRSP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DRSP_IDLE: begin
        if (req_c) begin
          if (lat_total_c == CNT_W'(1)) begin
            state_d = DRSP_RESP;
          end else begin
            state_d = DRSP_WAIT;
            cnt_d   = lat_total_c - CNT_W'(2);
          end
        end
      end
      DRSP_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DRSP_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRSP_RESP: state_d = DRSP_IDLE;
      default:   state_d = DRSP_IDLE;
    endcase
  end

  // Control outputs; with a one-cycle latency the access uses the live request directly.
  always_comb begin
    accept_c = 1'b0;
    drop_c   = 1'b0;
    access_c = 1'b0;
    acc_c    = req_q;
    if (state_q == DRSP_IDLE) begin
      acc_c    = live_c;
      accept_c = req_c;
    end else begin
      drop_c = req_c;
    end
    if ((state_q != DRSP_RESP) && (state_d == DRSP_RESP)) begin
      access_c = rst_n;
    end
  end

  always_comb begin
    word_off_c = acc_c.waddr - BASE_W;
    in_range_c = (acc_c.waddr >= BASE_W) && ((word_off_c >> IDX_W) == '0);
    idx_c      = word_off_c[IDX_W-1:0];
    rd_word_c  = mem[idx_c];
    // A preload to the same word in the same cycle supplies the unwritten lanes.
    wr_base_c  = (init_we && (init_idx == idx_c)) ? init_data : rd_word_c;
    mem_wr_c   = access_c && in_range_c && (acc_c.wmask != '0);
    err_set_c  = drop_c || (accept_c && !in_range_c);
  end

  // Array has no reset; the request write is ordered last so it wins a collision.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= init_data;
    end
    if (mem_wr_c) begin
      mem[idx_c] <= lane_merge(wr_base_c, acc_c.wdata, acc_c.wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
      dmem_err   <= 1'b0;
    end else begin
      dmem_resp <= access_c;
      if (accept_c) begin
        req_q <= live_c;
      end
      if (access_c) begin
        dmem_rdata <= in_range_c ? (rd_word_c & lane_bits(acc_c.rmask)) : '0;
      end
      if (err_set_c) begin
        dmem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (random-latency section under DMEM_RAND_LAT_EN).
module tb_dmem_responder;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned LATENCY   = 2;
  localparam logic [31:0] BASE      = 32'h1ECEB000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      dmem_addr;
  logic [3:0]       dmem_rmask;
  logic [3:0]       dmem_wmask;
  logic [31:0]      dmem_wdata;
  logic [31:0]      dmem_rdata;
  logic             dmem_resp;
  logic             init_we;
  logic [IDX_W-1:0] init_idx;
  logic [31:0]      init_data;
  logic             dmem_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] lat_seen = '0;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE),
    .LATENCY   (LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .init_we    (init_we),
    .init_idx   (init_idx),
    .init_data  (init_data),
    .dmem_err   (dmem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (dmem_resp !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    if (lat >= 20) chk("resp_timeout", 32'(dmem_resp), 32'd1);
  endtask

  // Issue one request, wait for its response, check latency and pulse width.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output logic [31:0] data);
    int lat;
    drive(a, rm, wm, wd);
    tick;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    wait_resp(lat);
`ifdef DMEM_RAND_LAT_EN
    chk("lat_range", 32'(lat >= LATENCY && lat <= LATENCY + 3), 32'd1);
    if (lat >= LATENCY && lat <= LATENCY + 3) lat_seen[lat - LATENCY] = 1'b1;
`else
    chk("latency", 32'(lat), 32'(LATENCY));
`endif
    data = dmem_rdata;
    tick;
    chk("resp_width", 32'(dmem_resp), 32'd0);
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [31:0] d);
    init_we   = 1'b1;
    init_idx  = idx;
    init_data = d;
    tick;
    init_we   = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  initial begin
    logic [31:0] d;
    int lat;
    rst_n     = 1'b0;
    init_we   = 1'b0;
    init_idx  = '0;
    init_data = '0;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    tick;
    tick;
    chk("rst_resp", 32'(dmem_resp), 32'd0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_err", 32'(dmem_err), 32'd0);
    rst_n = 1'b1;
    tick;

    preload(8'd4, 32'hDEADBEEF);
    preload(8'd0, 32'h12345678);

    do_req(32'h1ECEB010, 4'hF, 4'h0, 32'h0, d);
    chk("load_full", d, 32'hDEADBEEF);
    do_req(32'h1ECEB012, 4'h0, 4'b0100, 32'h00AA0000, d);
    chk("store_rdata_zero", d, 32'h0);
    do_req(32'h1ECEB010, 4'hF, 4'h0, 32'h0, d);
    chk("load_after_store", d, 32'hDEAABEEF);
    do_req(32'h1ECEB010, 4'b1100, 4'h0, 32'h0, d);
    chk("load_upper_half", d, 32'hDEAA0000);
    do_req(32'h1ECEB010, 4'hF, 4'b0001, 32'h00000011, d);
    chk("rw_old_word", d, 32'hDEAABEEF);
    do_req(32'h1ECEB010, 4'hF, 4'h0, 32'h0, d);
    chk("rw_write_applied", d, 32'hDEAABE11);
    chk("err_clean", 32'(dmem_err), 32'd0);

    // Out-of-range: one past the top, and one below the base.
    do_req(BASE + MEM_WORDS * 4, 4'hF, 4'h0, 32'h0, d);
    chk("oor_rdata", d, 32'h0);
    chk("oor_err", 32'(dmem_err), 32'd1);
    do_req(BASE + MEM_WORDS * 4, 4'h0, 4'hF, 32'hFFFFFFFF, d);
    do_req(32'h1ECEAFFC, 4'hF, 4'hF, 32'hFFFFFFFF, d);
    chk("below_rdata", d, 32'h0);
    do_req(BASE, 4'hF, 4'h0, 32'h0, d);
    chk("oor_no_write", d, 32'h12345678);
    chk("err_sticky", 32'(dmem_err), 32'd1);
    do_reset;
    chk("err_cleared", 32'(dmem_err), 32'd0);

    // Second request while the first is in flight is dropped.
    drive(32'h1ECEB010, 4'hF, 4'h0, 32'h0);
    tick;
    drive(32'h1ECEB010, 4'h0, 4'hF, 32'h0);
    tick;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    wait_resp(lat);
    chk("drop_first_rdata", dmem_rdata, 32'hDEAABE11);
    chk("drop_err", 32'(dmem_err), 32'd1);
    tick;
    do_req(32'h1ECEB010, 4'hF, 4'h0, 32'h0, d);
    chk("drop_no_write", d, 32'hDEAABE11);
    do_reset;

    // Reset during WAIT discards the pending store.
    drive(32'h1ECEB010, 4'h0, 4'hF, 32'hCAFEF00D);
    tick;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_resp0", 32'(dmem_resp), 32'd0);
    tick;
    chk("rst_wait_resp1", 32'(dmem_resp), 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("rst_wait_resp2", 32'(dmem_resp), 32'd0);
    chk("rst_wait_err", 32'(dmem_err), 32'd0);
    do_req(32'h1ECEB010, 4'hF, 4'h0, 32'h0, d);
    chk("rst_no_write", d, 32'hDEAABE11);

`ifndef DMEM_RAND_LAT_EN
    // Preload colliding with a store write: store lanes win, preload fills the rest.
    drive(32'h1ECEB014, 4'h0, 4'b0001, 32'h000000AA);
    tick;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    init_we = 1'b1; init_idx = 8'd5; init_data = 32'h55555555;
    tick;
    init_we = 1'b0;
    tick;
    do_req(32'h1ECEB014, 4'hF, 4'h0, 32'h0, d);
    chk("collide_merge", d, 32'h555555AA);
    // Preload at a load's access edge does not disturb that load's data.
    drive(32'h1ECEB014, 4'hF, 4'h0, 32'h0);
    tick;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    init_we = 1'b1; init_idx = 8'd5; init_data = 32'h0;
    tick;
    init_we = 1'b0;
    chk("init_load_resp", 32'(dmem_resp), 32'd1);
    chk("init_load_rdata", dmem_rdata, 32'h555555AA);
    tick;
    do_req(32'h1ECEB014, 4'hF, 4'h0, 32'h0, d);
    chk("init_after_load", d, 32'h0);
`else
    for (int i = 0; i < int'(MEM_WORDS); i++) preload(IDX_W'(i), 32'(i) * 32'h01010101 ^ 32'h5A5A0000);
    for (int n = 0; n < 1000; n++) begin
      int unsigned idx;
      logic [3:0] rm;
      idx = $urandom_range(0, MEM_WORDS - 1);
      rm  = 4'($urandom_range(1, 15));
      do_req(BASE + 32'(idx) * 4, rm, 4'h0, 32'h0, d);
      chk("rand_data", d, (32'(idx) * 32'h01010101 ^ 32'h5A5A0000) & lanes(rm));
    end
    chk("rand_all_lat_seen", 32'(lat_seen), 32'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
